// File: rtl/conv_window_3x3.sv
// 3x3 sliding-window builder fed by two cascaded line taps; emits stride-aligned,
// fully-inside windows with output-map coordinates and frame first/last markers.
module conv_window_3x3 #(
  parameter int WIDTH  = 16,
  parameter int COLS   = 224,
  parameter int ROWS   = 224,
  parameter int STRIDE = 1,
  localparam int CW    = $clog2(COLS),
  localparam int RW    = $clog2(ROWS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iclear,
  input  logic               ivalid,
  input  logic [WIDTH-1:0]   row0,
  input  logic [WIDTH-1:0]   row1,
  input  logic [WIDTH-1:0]   row2,
  output logic               ovalid,
  output logic [9*WIDTH-1:0] owindow,
  output logic [RW-1:0]      orow,
  output logic [CW-1:0]      ocol,
  output logic               ofirst,
  output logic               olast
);

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int LC = 2 + STRIDE * ((COLS - 3) / STRIDE);
  localparam int LR = 2 + STRIDE * ((ROWS - 3) / STRIDE);

  logic [9*WIDTH-1:0] tap_r;
  logic [9*WIDTH-1:0] tap_nxt_s;
  logic [CW-1:0]      col_r;
  logic [RW-1:0]      row_r;
  logic [PW-1:0]      cph_r;
  logic [PW-1:0]      rph_r;
  logic [CW-1:0]      oc_r;
  logic [RW-1:0]      or_r;
  logic               ovalid_r;
  logic [9*WIDTH-1:0] owindow_r;
  logic [RW-1:0]      orow_r;
  logic [CW-1:0]      ocol_r;
  logic               ofirst_r;
  logic               olast_r;
  logic               last_col_s;
  logic               last_row_s;
  logic               col_ge2_s;
  logic               row_ge2_s;
  logic               cph_wrap_s;
  logic               rph_wrap_s;
  logic               emit_s;
  logic               first_s;
  logic               last_s;

  // Shifted taps and emit/position decode for the current beat
  always_comb begin
    tap_nxt_s  = {row2, tap_r[8*WIDTH +: WIDTH], tap_r[7*WIDTH +: WIDTH],
                  row1, tap_r[5*WIDTH +: WIDTH], tap_r[4*WIDTH +: WIDTH],
                  row0, tap_r[2*WIDTH +: WIDTH], tap_r[1*WIDTH +: WIDTH]};
    last_col_s = (col_r == CW'(COLS - 1));
    last_row_s = (row_r == RW'(ROWS - 1));
    col_ge2_s  = (col_r >= CW'(2));
    row_ge2_s  = (row_r >= RW'(2));
    cph_wrap_s = (cph_r == PW'(STRIDE - 1));
    rph_wrap_s = (rph_r == PW'(STRIDE - 1));
    emit_s     = col_ge2_s && row_ge2_s && (cph_r == PW'(0)) && (rph_r == PW'(0));
    first_s    = (row_r == RW'(2)) && (col_r == CW'(2));
    last_s     = (row_r == RW'(LR)) && (col_r == CW'(LC));
  end

  // Tap shift, position/phase counters and registered window outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tap_r     <= '0;
      col_r     <= '0;
      row_r     <= '0;
      cph_r     <= '0;
      rph_r     <= '0;
      oc_r      <= '0;
      or_r      <= '0;
      ovalid_r  <= 1'b0;
      owindow_r <= '0;
      orow_r    <= '0;
      ocol_r    <= '0;
      ofirst_r  <= 1'b0;
      olast_r   <= 1'b0;
    end else if (iclear) begin
      col_r    <= '0;
      row_r    <= '0;
      cph_r    <= '0;
      rph_r    <= '0;
      oc_r     <= '0;
      or_r     <= '0;
      ovalid_r <= 1'b0;
    end else if (ivalid) begin
      tap_r    <= tap_nxt_s;
      ovalid_r <= emit_s;
      if (emit_s) begin
        owindow_r <= tap_nxt_s;
        orow_r    <= or_r;
        ocol_r    <= oc_r;
        ofirst_r  <= first_s;
        olast_r   <= last_s;
      end
      // oc_r/or_r hold the map index the next aligned column/row will carry
      if (last_col_s) begin
        col_r <= '0;
        cph_r <= '0;
        oc_r  <= '0;
        if (last_row_s) begin
          row_r <= '0;
          rph_r <= '0;
          or_r  <= '0;
        end else begin
          row_r <= row_r + RW'(1);
          if (row_ge2_s) begin
            rph_r <= rph_wrap_s ? PW'(0) : rph_r + PW'(1);
            if (rph_r == PW'(0)) begin
              or_r <= or_r + RW'(1);
            end
          end
        end
      end else begin
        col_r <= col_r + CW'(1);
        if (col_ge2_s) begin
          cph_r <= cph_wrap_s ? PW'(0) : cph_r + PW'(1);
          if (cph_r == PW'(0)) begin
            oc_r <= oc_r + CW'(1);
          end
        end
      end
    end else begin
      ovalid_r <= 1'b0;
    end
  end

  assign ovalid  = ovalid_r;
  assign owindow = owindow_r;
  assign orow    = orow_r;
  assign ocol    = ocol_r;
  assign ofirst  = ofirst_r;
  assign olast   = olast_r;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3: a 5x4 stride-1 instance and a 7x7 stride-2 instance,
// pixel value 16*r+c, expected windows and coordinates computed from (r,c).
module tb_conv_window_3x3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;

  logic          a_iclear = 1'b0, a_ivalid = 1'b0;
  logic [15:0]   a_row0 = '0, a_row1 = '0, a_row2 = '0;
  logic          a_ovalid, a_ofirst, a_olast;
  logic [143:0]  a_owindow;
  logic [1:0]    a_orow;
  logic [2:0]    a_ocol;

  logic          b_iclear = 1'b0, b_ivalid = 1'b0;
  logic [15:0]   b_row0 = '0, b_row1 = '0, b_row2 = '0;
  logic          b_ovalid, b_ofirst, b_olast;
  logic [143:0]  b_owindow;
  logic [2:0]    b_orow;
  logic [2:0]    b_ocol;

  int            n_total = 0;
  int            n_bad   = 0;
  int            win_cnt = 0;
  int            last_cnt = 0;

  logic          gv, gf, gl;
  logic [143:0]  gw;
  int            gr, gc;

  always #5 clock = ~clock;

  conv_window_3x3 #(.WIDTH(16), .COLS(5), .ROWS(4), .STRIDE(1)) u_a (
    .clock(clock), .reset(reset), .iclear(a_iclear), .ivalid(a_ivalid),
    .row0(a_row0), .row1(a_row1), .row2(a_row2),
    .ovalid(a_ovalid), .owindow(a_owindow), .orow(a_orow), .ocol(a_ocol),
    .ofirst(a_ofirst), .olast(a_olast));

  conv_window_3x3 #(.WIDTH(16), .COLS(7), .ROWS(7), .STRIDE(2)) u_b (
    .clock(clock), .reset(reset), .iclear(b_iclear), .ivalid(b_ivalid),
    .row0(b_row0), .row1(b_row1), .row2(b_row2),
    .ovalid(b_ovalid), .owindow(b_owindow), .orow(b_orow), .ocol(b_ocol),
    .ofirst(b_ofirst), .olast(b_olast));

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int r, input int c);
    if (r < 0) return 16'hBEEF;
    return 16'(16 * r + c);
  endfunction

  task automatic sample(input int sel);
    if (sel == 0) begin
      gv = a_ovalid; gw = a_owindow; gr = int'(a_orow); gc = int'(a_ocol);
      gf = a_ofirst; gl = a_olast;
    end else begin
      gv = b_ovalid; gw = b_owindow; gr = int'(b_orow); gc = int'(b_ocol);
      gf = b_ofirst; gl = b_olast;
    end
  endtask

  task automatic beat(input int sel, input logic v, input logic clr, input int r, input int c);
    if (sel == 0) begin
      a_ivalid = v; a_iclear = clr;
      a_row0 = pix(r - 2, c); a_row1 = pix(r - 1, c); a_row2 = pix(r, c);
    end else begin
      b_ivalid = v; b_iclear = clr;
      b_row0 = pix(r - 2, c); b_row1 = pix(r - 1, c); b_row2 = pix(r, c);
    end
    @(posedge clock);
    #1;
    a_ivalid = 1'b0; a_iclear = 1'b0; b_ivalid = 1'b0; b_iclear = 1'b0;
    sample(sel);
  endtask

  task automatic idle(input int sel);
    @(posedge clock);
    #1;
    sample(sel);
    check("gap_ovalid", 144'(gv), 144'(0));
  endtask

  // limit < 0 runs the whole frame, otherwise stops after that many beats
  task automatic run_frame(input int sel, input int cols, input int rows, input int s,
                           input bit gaps, input int limit);
    int n = 0;
    int lc = 2 + s * ((cols - 3) / s);
    int lr = 2 + s * ((rows - 3) / s);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        logic ex;
        logic [143:0] ew;
        if (n == limit) return;
        n++;
        if (gaps) begin
          int g = int'($urandom_range(0, 5));
          for (int i = 0; i < g; i++) idle(sel);
        end
        beat(sel, 1'b1, 1'b0, r, c);
        ex = (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
        check("ovalid", 144'(gv), 144'(ex));
        if (ex) begin
          win_cnt++;
          for (int k = 0; k < 9; k++) ew[k*16 +: 16] = pix(r - 2 + k / 3, c - 2 + k % 3);
          check("owindow", gw, ew);
          check("orow", 144'(gr), 144'((r - 2) / s));
          check("ocol", 144'(gc), 144'((c - 2) / s));
          check("ofirst", 144'(gf), 144'((r == 2) && (c == 2)));
          check("olast", 144'(gl), 144'((r == lr) && (c == lc)));
          if (gl) last_cnt++;
        end
      end
    end
  endtask

  task automatic totals(input string tag, input int ew, input int el);
    check({tag, "_nwin"}, 144'(win_cnt), 144'(ew));
    check({tag, "_nlast"}, 144'(last_cnt), 144'(el));
    win_cnt = 0;
    last_cnt = 0;
  endtask

  initial begin
    #3;
    check("rst_a_ovalid", 144'(a_ovalid), 144'(0));
    check("rst_a_owindow", a_owindow, 144'(0));
    check("rst_b_ovalid", 144'(b_ovalid), 144'(0));
    check("rst_b_pos", 144'({b_orow, b_ocol, b_ofirst, b_olast}), 144'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // T1 continuous 5x4 stride 1
    run_frame(0, 5, 4, 1, 1'b0, -1);
    totals("t1", 6, 1);
    // T2 7x7 stride 2
    run_frame(1, 7, 7, 2, 1'b0, -1);
    totals("t2", 9, 1);
    // T3 random ivalid gaps
    run_frame(0, 5, 4, 1, 1'b1, -1);
    totals("t3", 6, 1);
    // T4 two frames back to back
    run_frame(0, 5, 4, 1, 1'b0, -1);
    run_frame(0, 5, 4, 1, 1'b0, -1);
    totals("t4", 12, 2);

    // T5 iclear with ivalid at beat (2,2) drops that beat
    run_frame(0, 5, 4, 1, 1'b0, 12);
    beat(0, 1'b1, 1'b1, 2, 2);
    check("clr_drop_ovalid", 144'(gv), 144'(0));
    idle(0);
    totals("t5_pre", 0, 0);
    run_frame(0, 5, 4, 1, 1'b0, -1);
    totals("t5", 6, 1);

    // T6 asynchronous reset mid-frame, just after an emitted window
    run_frame(0, 5, 4, 1, 1'b0, 14);
    check("pre_rst_ovalid", 144'(a_ovalid), 144'(1));
    totals("t6_pre", 2, 0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_ovalid", 144'(a_ovalid), 144'(0));
    check("arst_owindow", a_owindow, 144'(0));
    check("arst_pos", 144'({a_orow, a_ocol, a_ofirst, a_olast}), 144'(0));
    @(negedge clock);
    reset = 1'b1;
    run_frame(0, 5, 4, 1, 1'b0, -1);
    totals("t6", 6, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
